// File: rtl/mul_share_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_share_ctrl_if : client request/response and multiplier port bundle   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mul_share_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               rsp0_valid;
  logic               rsp0_ready;
  logic               rsp1_valid;
  logic               rsp1_ready;
  logic [2*WIDTH-1:0] rsp_product;
  logic               mul_en;
  logic [WIDTH-1:0]   mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [2*WIDTH-1:0] mul_product;
  logic               busy;
  logic [15:0]        done_count;

  // Client datapaths plus the multiplier instance.
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, mul_product,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_product,
    input  mul_en, mul_mcand, mul_mplier, busy, done_count
  );

  // The sharing controller.
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, mul_product,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_product,
    output mul_en, mul_mcand, mul_mplier, busy, done_count
  );
endinterface
`default_nettype wire

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_share_ctrl : round-robin sharing of one pipelined multiplier         |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mul_share_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mul_share_ctrl_if.slave   bus
);

  localparam int HEAD = LATENCY - 1;

  logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [LATENCY-1:0] tag_id_q, tag_id_d;
  logic               last_grant_q, last_grant_d;
  logic [15:0]        done_count_q, done_count_d;

  logic head_valid;
  logic head_id;
  logic head_ready;
  logic advance;
  logic any_grant;
  logic grant_id;

  // Only a valid head whose owner refuses the product freezes the pipe.
  always_comb begin
    head_valid = tag_valid_q[HEAD];
    head_id    = tag_id_q[HEAD];
    head_ready = head_id ? bus.rsp1_ready : bus.rsp0_ready;
    advance    = !(head_valid && !head_ready);
    any_grant  = 1'b0;
    grant_id   = 1'b0;
    if (advance) begin
      if (bus.req0_valid && bus.req1_valid) begin
        any_grant = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (bus.req0_valid) begin
        any_grant = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        any_grant = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  always_comb begin
    tag_valid_d  = tag_valid_q;
    tag_id_d     = tag_id_q;
    last_grant_d = last_grant_q;
    done_count_d = done_count_q;
    if (advance) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        tag_valid_d[i] = tag_valid_q[i-1];
        tag_id_d[i]    = tag_id_q[i-1];
      end
      tag_valid_d[0] = any_grant;
      tag_id_d[0]    = grant_id;
    end
    if (any_grant) begin
      last_grant_d = grant_id;
    end
    if (head_valid && head_ready) begin
      done_count_d = done_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_q  <= '0;
      tag_id_q     <= '0;
      last_grant_q <= 1'b1;
      done_count_q <= '0;
    end else begin
      tag_valid_q  <= tag_valid_d;
      tag_id_q     <= tag_id_d;
      last_grant_q <= last_grant_d;
      done_count_q <= done_count_d;
    end
  end

  assign bus.req0_ready  = any_grant && (grant_id == 1'b0);
  assign bus.req1_ready  = any_grant && (grant_id == 1'b1);
  assign bus.mul_en      = advance;
  // Bubbles feed zeros so an idle multiplier does not toggle on stale operands.
  assign bus.mul_mcand   = !any_grant ? '0 : (grant_id ? bus.req1_a : bus.req0_a);
  assign bus.mul_mplier  = !any_grant ? '0 : (grant_id ? bus.req1_b : bus.req0_b);
  assign bus.rsp0_valid  = head_valid && (head_id == 1'b0);
  assign bus.rsp1_valid  = head_valid && (head_id == 1'b1);
  assign bus.rsp_product = bus.mul_product;
  assign bus.busy        = |tag_valid_q;
  assign bus.done_count  = done_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mul_share_ctrl : directed bench with a 2-stage multiplier model       |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mul_share_ctrl;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_share_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul_share_ctrl #(.WIDTH(WIDTH), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Multiplier: operand regs, then product reg, both en-gated.
  logic [WIDTH-1:0]   m_a, m_b;
  logic [2*WIDTH-1:0] m_p;
  always_ff @(posedge clk) begin
    if (reset) begin
      m_a <= '0;
      m_b <= '0;
      m_p <= '0;
    end else if (bus.mul_en) begin
      m_a <= bus.mul_mcand;
      m_b <= bus.mul_mplier;
      m_p <= {32'd0, m_a} * {32'd0, m_b};
    end
  end
  assign bus.mul_product = m_p;

  int          cyc = 0;
  bit          grant_log[$];
  bit          rsp_id_log[$];
  logic [63:0] rsp_prod_log[$];
  int          rsp_cyc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.req0_valid && bus.req0_ready) grant_log.push_back(1'b0);
      if (bus.req1_valid && bus.req1_ready) grant_log.push_back(1'b1);
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        rsp_id_log.push_back(1'b0);
        rsp_prod_log.push_back(bus.rsp_product);
        rsp_cyc_log.push_back(cyc);
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        rsp_id_log.push_back(1'b1);
        rsp_prod_log.push_back(bus.rsp_product);
        rsp_cyc_log.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
  endtask

  // Checks logged responses [base +: n] against expected id/product/cycle tables.
  task automatic check_rsp(input string tag, input int base, input int n,
                           input bit ids[8], input logic [63:0] prods[8], input int cycs[8]);
    check({tag, "_count"}, 64'(rsp_prod_log.size() - base), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (base + k < rsp_prod_log.size()) begin
        check({tag, "_id"},   64'(rsp_id_log[base+k]),  64'(ids[k]));
        check({tag, "_prod"}, rsp_prod_log[base+k],     prods[k]);
        check({tag, "_cyc"},  64'(rsp_cyc_log[base+k]), 64'(cycs[k]));
      end else begin
        check({tag, "_missing"}, 64'(1), 64'(0));
      end
    end
  endtask

  bit          ids[8];
  logic [63:0] prods[8];
  int          cycs[8];
  int          t0, rbase, gbase, c0, c1, exp_done;
  bit          g0, g1;
  bit          exp_gnt[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    idle_inputs();
    exp_done = 0;
    repeat (2) next_cyc();

    sample();
    check("rst_busy",  64'(bus.busy), 64'(0));
    check("rst_rsp0",  64'(bus.rsp0_valid), 64'(0));
    check("rst_rsp1",  64'(bus.rsp1_valid), 64'(0));
    check("rst_mul_en", 64'(bus.mul_en), 64'(1));
    check("rst_done",  64'(bus.done_count), 64'(0));
    next_cyc();
    reset = 1'b0;

    // Single op: 3*5 returns two cycles after acceptance.
    bus.req0_valid = 1'b1; bus.req0_a = 32'd3; bus.req0_b = 32'd5;
    sample();
    check("single_rdy0", 64'(bus.req0_ready), 64'(1));
    check("single_rdy1", 64'(bus.req1_ready), 64'(0));
    next_cyc();
    bus.req0_valid = 1'b0;
    sample();
    check("single_early", 64'(bus.rsp0_valid), 64'(0));
    next_cyc();
    sample();
    check("single_vld0", 64'(bus.rsp0_valid), 64'(1));
    check("single_prod", bus.rsp_product, 64'd15);
    check("single_vld1", 64'(bus.rsp1_valid), 64'(0));
    next_cyc();
    sample();
    exp_done = 1;
    check("single_done", 64'(bus.done_count), 64'(exp_done));
    check("single_busy", 64'(bus.busy), 64'(0));
    next_cyc();

    // Max operands; response readies low while the head is a bubble.
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'hFFFF_FFFF;
    sample();
    check("max_bubble_en", 64'(bus.mul_en), 64'(1));
    check("max_rdy1", 64'(bus.req1_ready), 64'(1));
    next_cyc();
    bus.req1_valid = 1'b0; bus.rsp1_ready = 1'b1;
    next_cyc();
    sample();
    check("max_vld1", 64'(bus.rsp1_valid), 64'(1));
    check("max_prod", bus.rsp_product, 64'hFFFF_FFFE_0000_0001);
    check("max_vld0", 64'(bus.rsp0_valid), 64'(0));
    next_cyc();
    bus.rsp0_ready = 1'b1;
    exp_done += 1;

    // Contention: last grant was req1, so req0 wins first and then strict alternation.
    t0 = cyc; rbase = rsp_prod_log.size(); gbase = grant_log.size();
    c0 = 1; c1 = 1;
    for (int i = 0; i < 6; i++) begin
      bus.req0_valid = 1'b1; bus.req0_a = 32'(2*c0); bus.req0_b = 32'(2*c0 + 1);
      bus.req1_valid = 1'b1; bus.req1_a = 32'(7*c1); bus.req1_b = 32'(7*c1 + 3);
      sample();
      g0 = bus.req0_ready; g1 = bus.req1_ready;
      next_cyc();
      if (g0) c0++;
      if (g1) c1++;
    end
    idle_inputs();
    repeat (4) next_cyc();
    check("ctn_gcount", 64'(grant_log.size() - gbase), 64'(6));
    for (int k = 0; k < 6; k++) begin
      if (gbase + k < grant_log.size())
        check("ctn_grant", 64'(grant_log[gbase+k]), 64'(exp_gnt[k]));
    end
    ids   = '{0, 1, 0, 1, 0, 1, 0, 0};
    prods = '{64'd6, 64'd70, 64'd20, 64'd238, 64'd42, 64'd504, 64'd0, 64'd0};
    for (int k = 0; k < 6; k++) cycs[k] = t0 + 2 + k;
    check_rsp("ctn", rbase, 6, ids, prods, cycs);
    exp_done += 6;

    // Backpressure: req1 owns the head for three refused cycles.
    t0 = cyc; rbase = rsp_prod_log.size();
    bus.req1_valid = 1'b1; bus.req1_a = 32'd9; bus.req1_b = 32'd11;
    sample();
    check("bp_rdy1", 64'(bus.req1_ready), 64'(1));
    next_cyc();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd4; bus.req0_b = 32'd6;
    sample();
    check("bp_rdy0", 64'(bus.req0_ready), 64'(1));
    next_cyc();
    bus.req0_a = 32'd8; bus.req0_b = 32'd8;
    bus.rsp1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("bp_mul_en", 64'(bus.mul_en), 64'(0));
      check("bp_rdy0_stall", 64'(bus.req0_ready), 64'(0));
      check("bp_rdy1_stall", 64'(bus.req1_ready), 64'(0));
      check("bp_vld1", 64'(bus.rsp1_valid), 64'(1));
      check("bp_hold", bus.rsp_product, 64'd99);
      next_cyc();
    end
    bus.rsp1_ready = 1'b1;
    sample();
    check("bp_release_rdy0", 64'(bus.req0_ready), 64'(1));
    next_cyc();
    bus.req0_valid = 1'b0;
    repeat (4) next_cyc();
    ids   = '{1, 0, 0, 0, 0, 0, 0, 0};
    prods = '{64'd99, 64'd24, 64'd64, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    cycs  = '{t0 + 5, t0 + 6, t0 + 7, 0, 0, 0, 0, 0};
    check_rsp("bp", rbase, 3, ids, prods, cycs);
    exp_done += 3;
    sample();
    check("bp_done", 64'(bus.done_count), 64'(exp_done));
    next_cyc();

    // Throughput: eight back-to-back req0 ops.
    t0 = cyc; rbase = rsp_prod_log.size();
    for (int i = 0; i < 8; i++) begin
      bus.req0_valid = 1'b1; bus.req0_a = 32'(i + 10); bus.req0_b = 32'(i + 20);
      sample();
      check("tp_rdy0", 64'(bus.req0_ready), 64'(1));
      next_cyc();
    end
    bus.req0_valid = 1'b0;
    repeat (3) next_cyc();
    ids   = '{0, 0, 0, 0, 0, 0, 0, 0};
    prods = '{64'd200, 64'd231, 64'd264, 64'd299, 64'd336, 64'd375, 64'd416, 64'd459};
    for (int k = 0; k < 8; k++) cycs[k] = t0 + 2 + k;
    check_rsp("tp", rbase, 8, ids, prods, cycs);
    exp_done += 8;
    sample();
    check("tp_done", 64'(bus.done_count), 64'(exp_done));
    next_cyc();

    // Reset with two ops in flight.
    bus.req0_valid = 1'b1; bus.req0_a = 32'd2; bus.req0_b = 32'd2;
    next_cyc();
    bus.req0_a = 32'd3; bus.req0_b = 32'd3;
    next_cyc();
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rmf_busy", 64'(bus.busy), 64'(0));
      check("rmf_vld0", 64'(bus.rsp0_valid), 64'(0));
      check("rmf_vld1", 64'(bus.rsp1_valid), 64'(0));
      if (i == 0) check("rmf_done", 64'(bus.done_count), 64'(0));
      next_cyc();
    end
    bus.req0_valid = 1'b1; bus.req0_a = 32'd6; bus.req0_b = 32'd7;
    sample();
    check("rmf_new_rdy", 64'(bus.req0_ready), 64'(1));
    next_cyc();
    bus.req0_valid = 1'b0;
    sample();
    check("rmf_new_early", 64'(bus.rsp0_valid), 64'(0));
    next_cyc();
    sample();
    check("rmf_new_vld", 64'(bus.rsp0_valid), 64'(1));
    check("rmf_new_prod", bus.rsp_product, 64'd42);
    next_cyc();
    sample();
    check("rmf_new_done", 64'(bus.done_count), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Round-robin arbiter and sequencer that shares one pipelined multiplier between two requesters. It grants one operand pair per cycle into the multiplier, tracks each in-flight operation's owner in a tag pipeline matched to the multiplier's register depth, and routes each product back to its requester. Response backpressure stalls the whole multiplier through its enable. The block sits between the two client datapaths and a single multiplier instance, driving the multiplier's operand and enable ports.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH
- LATENCY, 2, number of en-gated register stages in the multiplier (operand regs + stage reg); the multiplier's product output is combinational from its last stage

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- req0_valid / req1_valid  in  1  requester has an operand pair
- req0_ready / req1_ready  out  1  pair accepted this cycle (valid && ready)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  multiplicand, multiplier
- rsp0_valid / rsp1_valid  out  1  product for that requester is on rsp_product
- rsp0_ready / rsp1_ready  in  1  requester takes the product
- rsp_product  out  2*WIDTH  shared result bus, equal to mul_product
- mul_en  out  1  multiplier enable (pipeline advance)
- mul_mcand, mul_mplier  out  WIDTH  operands to the multiplier
- mul_product  in  2*WIDTH  multiplier result
- busy  out  1  any tag stage valid
- done_count  out  16  completed responses, wraps at 0xFFFF

## Operation
- Tag pipeline: LATENCY entries of {valid, id}. Entry LATENCY-1 is the head and aligns with mul_product.
- advance = !(head.valid && !rspX_ready[head.id]). mul_en = advance.
- Arbitration happens only when advance=1.
  - If exactly one req valid, grant it.
  - If both are valid, grant the requester that was not granted last (last_grant pointer).
  - reqX_ready = advance && grant==X. Ready is combinational, and may depend on rsp_ready.
- mul_mcand/mul_mplier take the granted pair. With no grant they are driven to 0 (bubble).
- On advance, the tag pipe shifts and entry 0 loads {any_grant, grant_id}. On a grant, last_grant updates. With no advance, the tag pipe and last_grant hold.
- rspX_valid = head.valid && head.id==X. rsp_product = mul_product at all times.
- A response completes when rspX_valid && rspX_ready. On completion, done_count increments by 1.
- Requesters must hold valid and operands stable until ready. Deasserting valid without a handshake is permitted; in that case no grant is made.
- Arithmetic is unsigned, full 2*WIDTH product with no truncation. The block performs no arithmetic itself.

## Timing
- Reset values:
  - Tag valids 0, last_grant=1 (req0 wins the first tie), done_count 0.
  - Outputs: rsp*_valid 0, busy 0, mul_en 1, req*_ready follow req*_valid arbitration.
- The multiplier's reset must be tied to the same reset.
- Latency: a pair accepted in cycle k yields rspX_valid in cycle k+LATENCY, provided there are no stalls. Each stall cycle adds 1.
- Throughput: 1 accept and 1 response per cycle, simultaneously, with no bubble.
- Stall: head blocked means mul_en=0, both req_ready=0, mul_product and rsp_product held stable, tags held. Nothing is lost or duplicated.
- A bubble at the head never stalls, whatever the state of rsp_ready.
- Both requesters valid continuously gives grants that alternate strictly 0,1,0,1...
- Reset mid-operation: all in-flight operations are discarded. No rsp_valid is produced in the cycles after reset deasserts until new requests propagate.
- done_count wraps 0xFFFF -> 0x0000.

## Test plan
- Single op: req0 a=3 b=5 accepted in cycle 0 -> rsp0_valid in cycle 2, rsp_product=15, rsp1_valid=0, done_count=1.
- Max operands: req1 a=b=0xFFFFFFFF -> rsp1 product 0xFFFFFFFE00000001.
- Contention: both valid for 6 cycles with distinct operands (req0 i*2, req1 i*7) -> grant order 0,1,0,1,0,1; each product is returned on the matching rsp in order, 1 per cycle.
- Backpressure: while the head belongs to req1, hold rsp1_ready=0 for 3 cycles. Required response:
  - mul_en=0 and req*_ready=0 for those 3 cycles.
  - rsp_product stays constant.
  - After release, all products are delivered exactly once.
- Throughput: 8 back-to-back req0 ops with rsp0_ready=1 -> req0_ready high for 8 consecutive cycles, 8 consecutive rsp0_valid cycles, done_count=8.
- Reset mid-flight: accept 2 ops, assert reset 1 cycle -> busy=0 and no rsp_valid afterwards; a new op then completes normally with latency 2.
